// File: rtl/router_out_sched_if.sv
// Request/grant/output bundle between the client FIFOs, the output scheduler and the downstream FIFO.
// The scheduler drives the slave side; the FIFO environment drives the master side.
interface router_out_sched_if #(
   parameter int NUM_CLIENTS = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int CREDITS     = 2
);
   localparam int ID_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int CNT_W = $clog2(CREDITS + 1);

   logic [NUM_CLIENTS-1:0]                 req_valid;
   logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] req_data;
   logic [NUM_CLIENTS-1:0]                 pop;
   logic                                   out_valid;
   logic [DATA_WIDTH-1:0]                  out_data;
   logic [ID_W-1:0]                        out_client_id;
   logic                                   credit_return;
   logic [CNT_W-1:0]                       credit_cnt;
   logic                                   credit_err;

   modport master (
      output req_valid, req_data, credit_return,
      input  pop, out_valid, out_data, out_client_id, credit_cnt, credit_err
   );

   modport slave (
      input  req_valid, req_data, credit_return,
      output pop, out_valid, out_data, out_client_id, credit_cnt, credit_err
   );
endinterface

// File: rtl/router_out_sched.sv
// Credit-gated round-robin output scheduler: pops one client FIFO per issue cycle and
// pushes the winner's payload into a downstream FIFO one cycle later.
module router_out_sched #(
   parameter int NUM_CLIENTS = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int CREDITS     = 2
) (
   input  logic              clk,
   input  logic              rst,
   router_out_sched_if.slave bus
);
   localparam int ID_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int CNT_W = $clog2(CREDITS + 1);
   localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_CLIENTS - 1);

   logic [ID_W-1:0]        rr_q, rr_d;
   logic [CNT_W-1:0]       credit_q, credit_d;
   logic                   err_q, err_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic [ID_W-1:0]        out_id_q, out_id_d;

   logic                   found;
   logic [ID_W-1:0]        winner;
   logic [ID_W-1:0]        idx;
   int                     sum;
   logic                   issue;
   logic [NUM_CLIENTS-1:0] pop;

   // Circular search starting at rr_q; first valid client wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      sum    = 0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         sum = int'(rr_q) + i;
         if (sum >= NUM_CLIENTS) sum = sum - NUM_CLIENTS;
         idx = ID_W'(sum);
         if (!found && bus.req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // A credit returned this cycle is only usable from the next cycle on.
   assign issue = !rst && (credit_q != '0) && found;
   assign pop   = issue ? (NUM_CLIENTS'(1) << winner) : '0;

   always_comb begin
      rr_d        = rr_q;
      credit_d    = credit_q;
      err_d       = err_q;
      out_valid_d = issue;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;

      if (issue) begin
         rr_d       = (winner == LAST_ID) ? '0 : winner + 1'b1;
         out_data_d = bus.req_data[winner];
         out_id_d   = winner;
      end

      case ({issue, bus.credit_return})
         2'b10: credit_d = credit_q - 1'b1;
         2'b01: begin
            if (credit_q == CRED_MAX) err_d = 1'b1;
            else                      credit_d = credit_q + 1'b1;
         end
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q        <= '0;
         credit_q    <= CRED_MAX;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         rr_q        <= rr_d;
         credit_q    <= credit_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end

   assign bus.pop           = pop;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.out_client_id = out_id_q;
   assign bus.credit_cnt    = credit_q;
   assign bus.credit_err    = err_q;
endmodule

// File: doc/router_out_sched.md
ROUTER_OUT_SCHED -- requirements
Module: router_out_sched

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4, the number of requesting input FIFOs.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the payload width per requester.
REQ-003 SHALL have parameter CREDITS, default 2, the downstream FIFO depth and the initial credit count.
REQ-004 SHALL have port clk  input  1  as the single clock; all state SHALL be updated on its rising edge.
REQ-005 SHALL have port rst  input  1  as the reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid  input  NUM_CLIENTS  as per-client not-empty indication from the input FIFO.
REQ-007 SHALL have port req_data  input  NUM_CLIENTS x DATA_WIDTH  as per-client head-of-FIFO payload.
REQ-008 SHALL have port pop  output  NUM_CLIENTS  as a one-hot, combinational pop to the winning client FIFO.
REQ-009 SHALL have port out_valid  output  1  as a single-cycle push strobe to the downstream FIFO.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  as the registered winner payload.
REQ-011 SHALL have port out_client_id  output  clog2(NUM_CLIENTS)  as the registered winner index.
REQ-012 SHALL have port credit_return  input  1  as a one-cycle pulse meaning one downstream entry was freed.
REQ-013 SHALL have port credit_cnt  output  clog2(CREDITS+1)  as the current credit count.
REQ-014 SHALL have port credit_err  output  1  as a sticky credit overflow flag.

Function
REQ-015 SHALL assert issue in a cycle exactly when credit_cnt != 0 and at least one req_valid bit is 1.
REQ-016 SHALL NOT count a credit_return arriving in a cycle toward issue in that same cycle.
REQ-017 SHALL, on issue, set exactly one pop bit, for the first client with req_valid set, searching circularly from rr_ptr.
REQ-018 SHALL hold pop at all-zero when issue is not asserted.
REQ-019 SHALL, on issue, load rr_ptr with (winner+1) mod NUM_CLIENTS on the next edge, and hold it otherwise.
REQ-020 SHALL register out_valid=1, out_data=req_data[winner] and out_client_id=winner one cycle after issue (latency 1).
REQ-021 SHALL deassert out_valid in any cycle that does not follow an issue cycle.
REQ-022 SHALL hold the last values of out_data and out_client_id while out_valid=0.
REQ-023 SHALL update credit_cnt per edge as follows: issue only -> -1; credit_return only -> +1; both -> unchanged; neither -> unchanged.
REQ-024 SHALL, when credit_return arrives with credit_cnt==CREDITS and no issue, leave credit_cnt at CREDITS and set credit_err=1.
REQ-025 SHALL keep credit_err at 1 until reset.
REQ-026 SHALL keep credit_cnt within 0..CREDITS under all input sequences.
REQ-027 SHALL allow back-to-back issues on consecutive cycles while credits remain.
REQ-028 SHALL continue to issue to a single active requester on every cycle while credits allow, with no fairness bubble.

Reset
REQ-029 SHALL, while rst=1, asynchronously force rr_ptr=0, credit_cnt=CREDITS, credit_err=0, out_valid=0, out_data=0 and out_client_id=0.
REQ-030 SHALL hold pop=0 while rst=1, regardless of req_valid.
REQ-031 SHALL, when reset occurs mid-operation, discard any pending output and restore full credits, with no out_valid pulse on the first edge after reset release.

Verification
REQ-032 SHALL be verified with: reset, then req_valid=4'b1111 held and credit_return pulsed every cycle -> pop sequence 0001,0010,0100,1000,0001 and out_client_id sequence 0,1,2,3,0, each one cycle after its pop.
REQ-033 SHALL be verified with: CREDITS=2, req_valid=4'b0100 held, no credit_return -> two pop pulses on client 2, credit_cnt 2->1->0, then pop=0 and out_valid=0 until a credit_return, after which exactly one more issue occurs.
REQ-034 SHALL be verified with: credit_cnt=1, issue and credit_return in the same cycle -> credit_cnt stays 1 and the next cycle issues again.
REQ-035 SHALL be verified with: credit_cnt=2 (full), credit_return pulse with no requests -> credit_cnt stays 2, credit_err=1, and credit_err stays 1 until rst.
REQ-036 SHALL be verified with: rr_ptr=3, req_valid=4'b0011 -> winner 0, then winner 1, then winner 0.
REQ-037 SHALL be verified with: rst asserted mid-cycle during an issue burst -> outputs clear immediately without waiting for a clock edge, and after release credit_cnt=CREDITS and the first grant goes to the lowest-index valid client.
